// File: rtl/bp_be_pkg.sv
// Shared types for the backend memory replay logic: replay FSM states and the
// held/in-flight op entry (valid bit + opaque dispatch packet).
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define DECLARE_BP_BE_REPLAY_ENTRY_S(pkt_width_mp) \
  typedef struct packed { \
    logic                    v; \
    logic [pkt_width_mp-1:0] pkt; \
  } bp_be_replay_entry_s;

package bp_be_pkg;

  typedef enum logic [1:0] {
    e_rb_ready   = 2'd0,
    e_rb_wait    = 2'd1,
    e_rb_replay0 = 2'd2,
    e_rb_replay1 = 2'd3
  } bp_be_replay_state_e;

  localparam int bp_be_pkt_width_gp = 256;
  localparam int bp_be_cnt_width_gp = 16;

endpackage

`endif

// File: rtl/bp_be_replay_shadow.sv
// Two-stage shadow of ops issued to the memory pipe (mem1 -> mem2).
// Valid bits are reset and clearable; packet data is an unreset shift register.
module bp_be_replay_shadow #(
  parameter int pkt_width_p = 256
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clr,
  input  logic                   vld_p0,
  input  logic [pkt_width_p-1:0] pkt_p0,
  output logic                   vld_p1,
  output logic [pkt_width_p-1:0] pkt_p1,
  output logic                   vld_p2,
  output logic [pkt_width_p-1:0] pkt_p2
);

  // p0 -> p1 (mem1) -> p2 (mem2)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    pkt_p1 <= pkt_p0;
    pkt_p2 <= pkt_p1;
  end

endmodule

// File: rtl/bp_be_mem_replay_buffer.sv
// Replay buffer in front of the memory pipe: passes dispatch packets through,
// and on a mem2 D$/D-TLB miss captures the missing op plus its follower and replays them.
module bp_be_mem_replay_buffer
  import bp_be_pkg::*;
#(
  parameter int pkt_width_p = bp_be_pkt_width_gp,
  parameter int cnt_width_p = bp_be_cnt_width_gp
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  input  logic                   pkt_v_i,
  input  logic [pkt_width_p-1:0] pkt_i,
  output logic                   ready_o,
  output logic                   pkt_v_o,
  output logic [pkt_width_p-1:0] pkt_o,
  input  logic                   mem_ready_i,
  input  logic                   cache_miss_v_i,
  input  logic                   tlb_miss_v_i,
  output logic                   kill_mem1_o,
  output logic                   busy_o,
  output logic [cnt_width_p-1:0] replay_cnt_o
);

  `DECLARE_BP_BE_REPLAY_ENTRY_S(pkt_width_p)

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] c);
    return (&c) ? c : c + cnt_width_p'(1);
  endfunction

  bp_be_replay_state_e state_q, state_n;

  logic                   vld_p1, vld_p2;
  logic [pkt_width_p-1:0] pkt_p1, pkt_p2;
  bp_be_replay_entry_s    mem1, mem2;

  logic                   hold0_v, hold1_v;
  logic [pkt_width_p-1:0] hold0_pkt, hold1_pkt;

  logic miss, take_miss, issue, rdy;

  assign mem1 = '{v: vld_p1, pkt: pkt_p1};
  assign mem2 = '{v: vld_p2, pkt: pkt_p2};

  // A flush squashes the missing op too, so it must not be captured or counted.
  assign miss      = (cache_miss_v_i | tlb_miss_v_i) & mem2.v;
  assign take_miss = miss & ~flush_i;

  always_comb begin
    state_n = state_q;
    rdy     = 1'b0;
    pkt_v_o = 1'b0;
    pkt_o   = pkt_i;
    unique case (state_q)
      e_rb_ready: begin
        rdy     = mem_ready_i & ~miss & ~flush_i;
        pkt_v_o = pkt_v_i & rdy;
      end
      e_rb_wait: begin
        if (mem_ready_i) state_n = e_rb_replay0;
      end
      e_rb_replay0: begin
        pkt_v_o = 1'b1;
        pkt_o   = hold0_pkt;
        if (mem_ready_i) state_n = hold1_v ? e_rb_replay1 : e_rb_ready;
      end
      e_rb_replay1: begin
        pkt_v_o = 1'b1;
        pkt_o   = hold1_pkt;
        if (mem_ready_i) state_n = e_rb_ready;
      end
    endcase
    if (take_miss) begin
      state_n = e_rb_wait;
      pkt_v_o = 1'b0;
    end
    if (flush_i) begin
      state_n = e_rb_ready;
      pkt_v_o = 1'b0;
      rdy     = 1'b0;
    end
    // Outputs drop as soon as reset asserts, not at the next edge.
    if (!reset_n_i) begin
      pkt_v_o = 1'b0;
      rdy     = 1'b0;
    end
  end

  assign ready_o     = rdy;
  assign kill_mem1_o = take_miss & reset_n_i;
  assign issue       = pkt_v_o & mem_ready_i;

  bp_be_replay_shadow #(
    .pkt_width_p(pkt_width_p)
  ) shadow (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clr      (take_miss | flush_i),
    .vld_p0   (issue),
    .pkt_p0   (pkt_o),
    .vld_p1   (vld_p1),
    .pkt_p1   (pkt_p1),
    .vld_p2   (vld_p2),
    .pkt_p2   (pkt_p2)
  );

  // Control state: FSM, registered busy, saturating replay counter, hold valids.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_rb_ready;
      busy_o       <= 1'b0;
      replay_cnt_o <= '0;
      hold0_v      <= 1'b0;
      hold1_v      <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_o  <= (state_n != e_rb_ready);
      if (flush_i) begin
        hold0_v <= 1'b0;
        hold1_v <= 1'b0;
      end else if (take_miss) begin
        replay_cnt_o <= sat_inc(replay_cnt_o);
        hold0_v      <= mem2.v;
        // A re-miss during REPLAY1 happens before hold1 was issued; keep it pending.
        if (state_q != e_rb_replay1) hold1_v <= mem1.v;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (take_miss) begin
      hold0_pkt <= mem2.pkt;
      if (state_q != e_rb_replay1) hold1_pkt <= mem1.pkt;
    end
  end

endmodule
